clk_div_ctrl: RTL

//  Sequences ratio changes for one clk_div instance. Accepts a new divide ratio over a valid/ready

---
 rtl/clk_div_ctrl_pkg.sv | 14 +
 rtl/clk_div_ctrl_period_cnt.sv | 35 +++
 rtl/clk_div_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the clk_div ratio-change controller.
// FSM encodings and the smallest legal divide ratio.
package clk_div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_SETTLE,
      ST_RUN,
      ST_DRAIN
   } state_e;

   localparam int MIN_RATIO = 2;

endpackage

// File: rtl/clk_div_ctrl_period_cnt.sv
// Shadow of the clk_div position counter.
// Flags the wrap edge of each divided period.
module clk_div_ctrl_period_cnt
   import clk_div_ctrl_pkg::*;
#(
   parameter int RATIO_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   run_i,
   input  logic [RATIO_WIDTH-1:0] ratio_i,
   output logic                   wrap_o
);

   logic [RATIO_WIDTH-1:0] cnt_q;
   logic [RATIO_WIDTH-1:0] cnt_d;

   assign wrap_o = run_i && (cnt_q == ratio_i - RATIO_WIDTH'(1));

   always_comb begin
      cnt_d = cnt_q + RATIO_WIDTH'(1);
      if (!run_i || wrap_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Ratio-change sequencer for one clk_div instance: drain, reset,
// settle, then re-enable the downstream clock gate and report lock.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int RATIO_WIDTH    = 8,
   parameter int DEFAULT_RATIO  = 2,
   parameter int RST_CYCLES     = 2,
   parameter int SETTLE_PERIODS = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_req_valid,
   input  logic [RATIO_WIDTH-1:0] i_req_ratio,
   output logic                   o_req_ready,
   output logic                   o_req_err,
   output logic [RATIO_WIDTH-1:0] o_div_ratio,
   output logic                   o_div_rst_n,
   output logic                   o_clk_en,
   output logic                   o_locked
);

   localparam int RCW = $clog2(RST_CYCLES + 1);
   localparam int PCW = $clog2(SETTLE_PERIODS + 1);

   state_e                 state_q, state_d;
   logic [RCW-1:0]         rcnt_q, rcnt_d;
   logic [PCW-1:0]         pcnt_q, pcnt_d;
   logic [RATIO_WIDTH-1:0] pend_q, pend_d;
   logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
   logic                   rstn_q, rstn_d;
   logic                   en_q, en_d;
   logic                   lock_q, lock_d;
   logic                   rdy_q, rdy_d;
   logic                   err_q, err_d;
   logic                   wrap;
   logic                   accept;

   clk_div_ctrl_period_cnt #(
      .RATIO_WIDTH(RATIO_WIDTH)
   ) u_period_cnt (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .run_i  (rstn_q),
      .ratio_i(ratio_q),
      .wrap_o (wrap)
   );

   assign accept = i_req_valid && rdy_q;

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      pcnt_d  = pcnt_q;
      pend_d  = pend_q;
      ratio_d = ratio_q;
      rstn_d  = rstn_q;
      en_d    = en_q;
      lock_d  = lock_q;
      rdy_d   = rdy_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_RESET: begin
            if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
               state_d = ST_SETTLE;
               rcnt_d  = '0;
               rstn_d  = 1'b1;
            end else begin
               rcnt_d = rcnt_q + RCW'(1);
            end
         end
         ST_SETTLE: begin
            if (wrap) begin
               if (pcnt_q == PCW'(SETTLE_PERIODS - 1)) begin
                  state_d = ST_RUN;
                  pcnt_d  = '0;
                  en_d    = 1'b1;
                  lock_d  = 1'b1;
                  rdy_d   = 1'b1;
               end else begin
                  pcnt_d = pcnt_q + PCW'(1);
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (i_req_ratio < RATIO_WIDTH'(MIN_RATIO)) begin
                  err_d = 1'b1;
               end else if (i_req_ratio != ratio_q) begin
                  state_d = ST_DRAIN;
                  pend_d  = i_req_ratio;
                  lock_d  = 1'b0;
                  rdy_d   = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            // Gate only at a period boundary so no runt pulse escapes.
            if (wrap) begin
               state_d = ST_RESET;
               en_d    = 1'b0;
               rstn_d  = 1'b0;
               ratio_d = pend_q;
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_RESET;
         rcnt_q  <= '0;
         pcnt_q  <= '0;
         pend_q  <= RATIO_WIDTH'(DEFAULT_RATIO);
         ratio_q <= RATIO_WIDTH'(DEFAULT_RATIO);
         rstn_q  <= 1'b0;
         en_q    <= 1'b0;
         lock_q  <= 1'b0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         pcnt_q  <= pcnt_d;
         pend_q  <= pend_d;
         ratio_q <= ratio_d;
         rstn_q  <= rstn_d;
         en_q    <= en_d;
         lock_q  <= lock_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
      end
   end

   assign o_req_ready = rdy_q;
   assign o_req_err   = err_q;
   assign o_div_ratio = ratio_q;
   assign o_div_rst_n = rstn_q;
   assign o_clk_en    = en_q;
   assign o_locked    = lock_q;

endmodule
